i2c_target_regs: RTL



---
 rtl/i2c_target_regs.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_target_regs.sv
// I2C target with a byte-addressed register file: acknowledges TARGET_ADDR,
// takes a register pointer, then streams writes into or reads out of the file.
module i2c_target_regs #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         PTR_W       = 4,
  parameter logic [7:0] RESET_DATA  = 8'h00
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic             SCL,
  input  logic             SDA,
  output logic             SDA_ENABLE,
  output logic             BUSY,
  output logic             RX_VALID,
  output logic [PTR_W-1:0] RX_ADDR,
  output logic [7:0]       RX_DATA
);

  localparam int DEPTH = 2 ** PTR_W;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, WDATA, WACK, RDATA, RACK, IGNORE
  } state_t;

  logic [1:0]       scl_sync_reg, sda_sync_reg;
  logic             scl_hist_reg, sda_hist_reg;
  logic             scl_s, sda_s;
  logic             scl_rise, scl_fall, scl_edge, start_det, stop_det;

  state_t           state_reg, state_next;
  logic [2:0]       bit_cnt_reg, bit_cnt_next;
  logic [7:0]       shift_reg, shift_next;
  logic [7:0]       tx_reg, tx_next;
  logic [PTR_W-1:0] ptr_reg, ptr_next;
  logic             ack_on_reg, ack_on_next;
  logic             rw_reg, rw_next;
  logic             rack_ok_reg, rack_ok_next;
  logic             drive_reg, drive_next;
  logic             sda_en_reg;
  logic             busy_reg, busy_next;
  logic             rx_valid_reg, rx_valid_next;
  logic [PTR_W-1:0] rx_addr_reg, rx_addr_next;
  logic [7:0]       rx_data_reg, rx_data_next;
  logic [7:0]       shifted;
  logic             wr_en;

  logic [7:0]       mem_reg [DEPTH];
  logic [7:0]       rd_data_reg;

  // Two-stage synchronizers plus one history stage per line.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      scl_sync_reg <= 2'b11;
      sda_sync_reg <= 2'b11;
      scl_hist_reg <= 1'b1;
      sda_hist_reg <= 1'b1;
    end else begin
      scl_sync_reg <= {scl_sync_reg[0], SCL};
      sda_sync_reg <= {sda_sync_reg[0], SDA};
      scl_hist_reg <= scl_sync_reg[1];
      sda_hist_reg <= sda_sync_reg[1];
    end
  end

  assign scl_s    = scl_sync_reg[1];
  assign sda_s    = sda_sync_reg[1];
  assign scl_rise = scl_s & ~scl_hist_reg;
  assign scl_fall = ~scl_s & scl_hist_reg;
  assign scl_edge = scl_s ^ scl_hist_reg;
  // An SCL edge in the same sample masks any SDA change.
  assign start_det = ~scl_edge & scl_s & scl_hist_reg & sda_hist_reg & ~sda_s;
  assign stop_det  = ~scl_edge & scl_s & scl_hist_reg & ~sda_hist_reg & sda_s;
  assign shifted   = {shift_reg[6:0], sda_s};

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= 3'd0;
      shift_reg    <= 8'd0;
      tx_reg       <= 8'd0;
      ptr_reg      <= '0;
      ack_on_reg   <= 1'b0;
      rw_reg       <= 1'b0;
      rack_ok_reg  <= 1'b0;
      drive_reg    <= 1'b0;
      sda_en_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      rx_valid_reg <= 1'b0;
      rx_addr_reg  <= '0;
      rx_data_reg  <= 8'd0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      tx_reg       <= tx_next;
      ptr_reg      <= ptr_next;
      ack_on_reg   <= ack_on_next;
      rw_reg       <= rw_next;
      rack_ok_reg  <= rack_ok_next;
      drive_reg    <= drive_next;
      sda_en_reg   <= drive_reg;
      busy_reg     <= busy_next;
      rx_valid_reg <= rx_valid_next;
      rx_addr_reg  <= rx_addr_next;
      rx_data_reg  <= rx_data_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    tx_next       = tx_reg;
    ptr_next      = ptr_reg;
    ack_on_next   = ack_on_reg;
    rw_next       = rw_reg;
    rack_ok_next  = rack_ok_reg;
    drive_next    = drive_reg;
    busy_next     = busy_reg;
    rx_valid_next = 1'b0;
    rx_addr_next  = rx_addr_reg;
    rx_data_next  = rx_data_reg;
    wr_en         = 1'b0;

    if (start_det) begin
      state_next   = ADDR;
      bit_cnt_next = 3'd0;
      ack_on_next  = 1'b0;
      rack_ok_next = 1'b0;
      drive_next   = 1'b0;
    end else if (stop_det) begin
      state_next   = IDLE;
      drive_next   = 1'b0;
      busy_next    = 1'b0;
      ack_on_next  = 1'b0;
      rack_ok_next = 1'b0;
    end else begin
      case (state_reg)
        ADDR: begin
          if (scl_rise) begin
            shift_next   = shifted;
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              rw_next = sda_s;
              if (shifted[7:1] == TARGET_ADDR) begin
                busy_next   = 1'b1;
                ack_on_next = 1'b0;
                state_next  = ADDR_ACK;
              end else begin
                busy_next  = 1'b0;
                state_next = IGNORE;
              end
            end
          end
        end
        ADDR_ACK: begin
          // First fall starts the ACK, the second ends it.
          if (scl_fall) begin
            if (!ack_on_reg) begin
              drive_next  = 1'b1;
              ack_on_next = 1'b1;
            end else begin
              ack_on_next  = 1'b0;
              bit_cnt_next = 3'd0;
              if (rw_reg) begin
                state_next = RDATA;
                tx_next    = rd_data_reg;
                drive_next = ~rd_data_reg[7];
              end else begin
                state_next = PTR;
                drive_next = 1'b0;
              end
            end
          end
        end
        PTR: begin
          if (scl_rise) begin
            shift_next   = shifted;
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              ptr_next    = shifted[PTR_W-1:0];
              ack_on_next = 1'b0;
              state_next  = WACK;
            end
          end
        end
        WDATA: begin
          if (scl_rise) begin
            shift_next   = shifted;
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              wr_en         = 1'b1;
              rx_valid_next = 1'b1;
              rx_addr_next  = ptr_reg;
              rx_data_next  = shifted;
              ptr_next      = ptr_reg + 1'b1;
              ack_on_next   = 1'b0;
              state_next    = WACK;
            end
          end
        end
        WACK: begin
          if (scl_fall) begin
            if (!ack_on_reg) begin
              drive_next  = 1'b1;
              ack_on_next = 1'b1;
            end else begin
              ack_on_next  = 1'b0;
              drive_next   = 1'b0;
              bit_cnt_next = 3'd0;
              state_next   = WDATA;
            end
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (bit_cnt_reg == 3'd7) begin
              drive_next   = 1'b0;
              bit_cnt_next = 3'd0;
              rack_ok_next = 1'b0;
              state_next   = RACK;
            end else begin
              tx_next      = {tx_reg[6:0], 1'b0};
              drive_next   = ~tx_reg[6];
              bit_cnt_next = bit_cnt_reg + 3'd1;
            end
          end
        end
        RACK: begin
          // The next byte is fetched between the ACK rise and the following fall.
          if (scl_rise) begin
            if (sda_s) begin
              state_next = IGNORE;
            end else begin
              ptr_next     = ptr_reg + 1'b1;
              rack_ok_next = 1'b1;
            end
          end else if (scl_fall && rack_ok_reg) begin
            rack_ok_next = 1'b0;
            tx_next      = rd_data_reg;
            drive_next   = ~rd_data_reg[7];
            bit_cnt_next = 3'd0;
            state_next   = RDATA;
          end
        end
        IGNORE: drive_next = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= RESET_DATA;
      rd_data_reg <= RESET_DATA;
    end else begin
      if (wr_en) mem_reg[ptr_reg] <= shifted;
      rd_data_reg <= mem_reg[ptr_reg];
    end
  end

  assign SDA_ENABLE = sda_en_reg;
  assign BUSY       = busy_reg;
  assign RX_VALID   = rx_valid_reg;
  assign RX_ADDR    = rx_addr_reg;
  assign RX_DATA    = rx_data_reg;

endmodule
